// File: rtl/pulse_gen.sv
// Trigger-started level pulse with programmable delay and width, then a forced idle gap.
// Registered outputs; trigger-to-first-active latency 1+dly; triggers while busy are dropped and flagged.
module pulse_gen #(
    parameter int   CNT_W    = 16,
    parameter logic IDLE_LVL = 1'b1,
    parameter int   MIN_GAP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [CNT_W-1:0] dly,
    input  logic [CNT_W-1:0] wid,
    output logic             sig,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(MIN_GAP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic             sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic             accept;
    logic [CNT_W-1:0] wid_eff;

    assign wid_eff = (wid == '0) ? CNT_ONE : wid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wid_d   = wid_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept = trig;
            end
            S_DELAY: begin
                drop_d = trig;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_ACTIVE;
                    sig_d   = ~IDLE_LVL;
                    cnt_d   = wid_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_ACTIVE: begin
                drop_d = trig;
                if (cnt_q == CNT_ONE) begin
                    sig_d  = IDLE_LVL;
                    done_d = 1'b1;
                    if (MIN_GAP == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                // By the last gap cycle sig has already been idle MIN_GAP cycles,
                // so a trigger on that edge starts the next pulse directly.
                if (cnt_q == CNT_ONE) begin
                    if (trig) begin
                        accept = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    drop_d = trig;
                    cnt_d  = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            busy_d = 1'b1;
            wid_d  = wid_eff;
            if (dly == '0) begin
                state_d = S_ACTIVE;
                sig_d   = ~IDLE_LVL;
                cnt_d   = wid_eff;
            end else begin
                state_d = S_DELAY;
                cnt_d   = dly;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wid_q   <= '0;
            sig_q   <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wid_q   <= wid_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign sig  = sig_q;
    assign busy = busy_q;
    assign done = done_q;
    assign drop = drop_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: per-cycle expectations are queued with the stimulus and popped as each edge is sampled.
module tb_pulse_gen;

    logic        clk;
    logic        rst_n;
    logic        trig;
    logic [15:0] dly;
    logic [15:0] wid;
    logic        sig, busy, done, drop;
    logic        trig2;
    logic [3:0]  dly2;
    logic [3:0]  wid2;
    logic        sig2, busy2, done2, drop2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        trig;
        logic [15:0] dly;
        logic [15:0] wid;
        logic [3:0]  exp;   // {sig, busy, done, drop}
    } ent_t;

    ent_t exp_q[$];

    pulse_gen #(.CNT_W(16), .IDLE_LVL(1'b1), .MIN_GAP(2)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (trig),
        .dly  (dly),
        .wid  (wid),
        .sig  (sig),
        .busy (busy),
        .done (done),
        .drop (drop)
    );

    pulse_gen #(.CNT_W(4), .IDLE_LVL(1'b1), .MIN_GAP(0)) u_small (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (trig2),
        .dly  (dly2),
        .wid  (wid2),
        .sig  (sig2),
        .busy (busy2),
        .done (done2),
        .drop (drop2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    // Expected timeline of one accepted pulse, k = cycles after the accepting edge.
    function automatic void push_pulse(int d, int w_in, int g, int ncyc);
        ent_t e;
        int   w;
        w = (w_in == 0) ? 1 : w_in;
        for (int k = 0; k < ncyc; k++) begin
            e.trig   = (k == 0);
            e.dly    = (k == 0) ? 16'(d) : 16'($urandom);
            e.wid    = (k == 0) ? 16'(w_in) : 16'($urandom);
            e.exp[3] = (k >= d && k < d + w) ? 1'b0 : 1'b1;
            e.exp[2] = (k < d + w + g);
            e.exp[1] = (k == d + w);
            e.exp[0] = 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic test_reset();
        ent_t e;
        int   k;
        rst_n = 1'b1;
        trig  = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trig = i[0];
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== 4'b1000) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b want 1000", i, {sig, busy, done, drop});
            end
        end
        rst_n = 1'b1;
        push_pulse(0, 2, 2, 6);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trig = e.trig; dly = e.dly; wid = e.wid;
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== e.exp) begin
                errors++;
                $display("FAIL reset_release cycle %0d: got %b want %b", k, {sig, busy, done, drop}, e.exp);
            end
            k++;
        end
        trig = 1'b0;
    endtask

    task automatic test_basic();
        ent_t e;
        int   k;
        int   falls;
        logic prev;
        push_pulse(0, 4, 2, 8);
        k = 0; falls = 0; prev = sig;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trig = e.trig; dly = e.dly; wid = e.wid;
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== e.exp) begin
                errors++;
                $display("FAIL basic cycle %0d: got %b want %b", k, {sig, busy, done, drop}, e.exp);
            end
            if (prev === 1'b1 && sig === 1'b0) falls++;
            prev = sig;
            k++;
        end
        trig = 1'b0;
        checks++;
        if (falls != 1) begin
            errors++;
            $display("FAIL basic_edges: got %0d falling edges want 1", falls);
        end
    endtask

    task automatic test_delay_zero_width();
        ent_t e;
        int   k;
        push_pulse(3, 0, 2, 8);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trig = e.trig; dly = e.dly; wid = e.wid;
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== e.exp) begin
                errors++;
                $display("FAIL delay_zero_wid cycle %0d: got %b want %b", k, {sig, busy, done, drop}, e.exp);
            end
            k++;
        end
        trig = 1'b0;
    endtask

    task automatic test_busy_overlap();
        ent_t e;
        int   k;
        push_pulse(0, 5, 2, 9);
        for (int i = 2; i <= 3; i++) begin
            exp_q[i].trig   = 1'b1;
            exp_q[i].exp[0] = 1'b1;
        end
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trig = e.trig; dly = e.dly; wid = e.wid;
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== e.exp) begin
                errors++;
                $display("FAIL busy_overlap cycle %0d: got %b want %b", k, {sig, busy, done, drop}, e.exp);
            end
            k++;
        end
        trig = 1'b0;
    endtask

    task automatic test_min_gap();
        ent_t e;
        int   k;
        push_pulse(0, 2, 2, 4);
        exp_q[3].trig   = 1'b1;
        exp_q[3].exp[0] = 1'b1;
        push_pulse(0, 2, 2, 6);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trig = e.trig; dly = e.dly; wid = e.wid;
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== e.exp) begin
                errors++;
                $display("FAIL min_gap cycle %0d: got %b want %b", k, {sig, busy, done, drop}, e.exp);
            end
            k++;
        end
        trig = 1'b0;
    endtask

    task automatic test_mid_reset();
        ent_t e;
        int   k;
        push_pulse(0, 100, 2, 5);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trig = e.trig; dly = e.dly; wid = e.wid;
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== e.exp) begin
                errors++;
                $display("FAIL mid_reset_pre cycle %0d: got %b want %b", k, {sig, busy, done, drop}, e.exp);
            end
            k++;
        end
        trig = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({sig, busy, done, drop} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want 1000", {sig, busy, done, drop});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sig, busy, done, drop} !== 4'b1000) begin
                errors++;
                $display("FAIL mid_reset_after cycle %0d: got %b want 1000", i, {sig, busy, done, drop});
            end
        end
    endtask

    task automatic test_max_small();
        ent_t e;
        int   k;
        push_pulse(15, 15, 0, 31);
        push_pulse(0, 1, 0, 3);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            trig2 = e.trig; dly2 = e.dly[3:0]; wid2 = e.wid[3:0];
            @(posedge clk); #1;
            checks++;
            if ({sig2, busy2, done2, drop2} !== e.exp) begin
                errors++;
                $display("FAIL max_small cycle %0d: got %b want %b", k, {sig2, busy2, done2, drop2}, e.exp);
            end
            k++;
        end
        trig2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        trig  = 1'b0;
        dly   = '0;
        wid   = '0;
        trig2 = 1'b0;
        dly2  = '0;
        wid2  = '0;
        test_reset();
        test_basic();
        test_delay_zero_width();
        test_busy_overlap();
        test_min_gap();
        test_mid_reset();
        test_max_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
